inv_mix_columns_iter: RTL

Iterative InvMixColumns engine for the AES-128 decryption datapath, the inverse counterpart of the encryption core's MixColumns stage. It accepts a 128-bit state over a valid/ready handshake and multiplies each column by the inverse MDS matrix {0e,0b,0d,09} over GF(2^8), processing COLS_PER_CYCLE columns per clock. The operation is bypassed on the final decryption round. The block sits between AddRoundKey and the round register in the inverse-cipher round loop.

---
 rtl/inv_mix_columns_iter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/inv_mix_columns_iter.sv
`default_nettype none
// ============================================================================
// Module   : inv_mix_columns_iter
// Brief    : Iterative AES InvMixColumns engine. Takes a 128-bit state over
//            valid/ready, multiplies each column by {0e,0b,0d,09} over
//            GF(2^8), COLS_PER_CYCLE columns per clock. Rounds at or above
//            NUM_ROUNDS pass the state through unchanged.
// Revision : 1.0 - initial release
// ============================================================================
module inv_mix_columns_iter #(
  parameter int COLS_PER_CYCLE = 1,
  parameter int NUM_ROUNDS     = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_text,
  input  logic [3:0]   in_round,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_text,
  output logic         busy
);

  // Only 1, 2 and 4 divide the four columns evenly.
  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("inv_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0]  S_IDLE = 2'd0;
  localparam logic [1:0]  S_BUSY = 2'd1;
  localparam logic [1:0]  S_DONE = 2'd2;

  // Step of 4 truncates to 0 in two bits, which is harmless: with four
  // columns per cycle the first group is also the last one.
  localparam logic [1:0]  c_STEP       = 2'(COLS_PER_CYCLE);
  localparam logic [1:0]  c_LAST_GROUP = 2'(4 - COLS_PER_CYCLE);
  localparam logic [31:0] c_NUM_ROUNDS = 32'(NUM_ROUNDS);

  logic [1:0]   state_q,   state_d;
  logic [127:0] data_q,    data_d;
  logic [1:0]   col_idx_q, col_idx_d;

  logic         w_bypass;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column through the inverse MDS matrix; row 0 is the top byte.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a   [4];
    logic [7:0] x2  [4];
    logic [7:0] x4  [4];
    logic [7:0] x8  [4];
    logic [7:0] m9  [4];
    logic [7:0] m11 [4];
    logic [7:0] m13 [4];
    logic [7:0] m14 [4];
    for (int i = 0; i < 4; i++) begin
      a[i]   = col[31-8*i -: 8];
      x2[i]  = xtime(a[i]);
      x4[i]  = xtime(x2[i]);
      x8[i]  = xtime(x4[i]);
      m9[i]  = x8[i] ^ a[i];
      m11[i] = x8[i] ^ x2[i] ^ a[i];
      m13[i] = x8[i] ^ x4[i] ^ a[i];
      m14[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
            m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
            m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
            m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
  endfunction

  assign w_bypass = {28'd0, in_round} >= c_NUM_ROUNDS;

  // Next-state logic: accept, transform the current column group in place, hand off.
  always_comb begin
    logic [1:0] idx;
    logic [6:0] base;
    state_d   = state_q;
    data_d    = data_q;
    col_idx_d = col_idx_q;
    idx       = 2'd0;
    base      = 7'd0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          data_d    = in_text;
          col_idx_d = 2'd0;
          state_d   = w_bypass ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
          idx  = col_idx_q + 2'(g);
          // Column 0 sits in the top word, so its LSB offset is (3-idx)*32.
          base = {~idx, 5'b0};
          data_d[base +: 32] = inv_mix_col(data_q[base +: 32]);
        end
        if (col_idx_q == c_LAST_GROUP) begin
          col_idx_d = 2'd0;
          state_d   = S_DONE;
        end else begin
          col_idx_d = col_idx_q + c_STEP;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d   = S_IDLE;
        col_idx_d = 2'd0;
      end
    endcase
  end

  // State registers; reset discards any state in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      data_q    <= '0;
      col_idx_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      col_idx_q <= col_idx_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_BUSY);
  assign out_valid = (state_q == S_DONE);
  assign out_text  = data_q;

endmodule
`default_nettype wire
